// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-cache slow-memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  function automatic arb_state_t serve_state(input req_id_t id);
    return (id == REQ_D) ? SERVE_D : SERVE_I;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way request picker: fixed D priority or alternate against the last grant.
module mem_arb_rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic    pend_i,
  input  logic    pend_d,
  input  req_id_t last_grant,
  output req_id_t grant,
  output logic    grant_valid
);

  // choose the winner among the pending requesters
  always_comb begin
    grant       = REQ_I;
    grant_valid = 1'b0;
    case ({pend_d, pend_i})
      2'b01: begin
        grant       = REQ_I;
        grant_valid = 1'b1;
      end
      2'b10: begin
        grant       = REQ_D;
        grant_valid = 1'b1;
      end
      2'b11: begin
        grant_valid = 1'b1;
        if (FIXED_PRI != 0) begin
          grant = REQ_D;
        end else if (last_grant == REQ_I) begin
          grant = REQ_D;
        end else begin
          grant = REQ_I;
        end
      end
      default: begin
        grant       = REQ_I;
        grant_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache line ports onto one unified slow memory,
// holding each grant until mem_ready and flagging over-long transactions.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRI = 0,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam int               CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
  localparam bit               TO_EN    = (TIMEOUT > 0);

  arb_state_t        state_r;
  arb_state_t        state_next_s;
  req_id_t           last_grant_r;
  req_id_t           pick_s;
  logic              pick_valid_s;
  logic              grant_s;
  logic              serving_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_read_s;
  logic              sel_write_s;
  logic              mem_read_r;
  logic              mem_write_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [CNT_W-1:0]  to_cnt_r;
  logic              timeout_err_r;

  mem_arb_rr_pick #(
    .FIXED_PRI (FIXED_PRI)
  ) u_pick (
    .pend_i      (i_read | i_write),
    .pend_d      (d_read | d_write),
    .last_grant  (last_grant_r),
    .grant       (pick_s),
    .grant_valid (pick_valid_s)
  );

  assign grant_s   = (state_r == IDLE) && pick_valid_s;
  assign serving_s = (state_r != IDLE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic: one IDLE cycle separates consecutive grants
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_next_s = serve_state(pick_s);
        end else begin
          state_next_s = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // outputs: only the served requester sees mem_ready
  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    case (state_r)
      SERVE_I: i_ready = mem_ready;
      SERVE_D: d_ready = mem_ready;
      default: begin
        i_ready = 1'b0;
        d_ready = 1'b0;
      end
    endcase
  end

  // select the winner's bundle; a simultaneous read and write is a write
  always_comb begin
    if (pick_s == REQ_D) begin
      sel_addr_s  = d_addr;
      sel_wdata_s = d_wdata;
      sel_write_s = d_write;
      sel_read_s  = d_read & ~d_write;
    end else begin
      sel_addr_s  = i_addr;
      sel_wdata_s = i_wdata;
      sel_write_s = i_write;
      sel_read_s  = i_read & ~i_write;
    end
  end

  // memory-side registers, latched once per grant and held through SERVE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      last_grant_r <= REQ_I;
    end else if (grant_s) begin
      mem_read_r   <= sel_read_s;
      mem_write_r  <= sel_write_s;
      mem_addr_r   <= sel_addr_s;
      mem_wdata_r  <= sel_wdata_s;
      last_grant_r <= pick_s;
    end else if (serving_s && mem_ready) begin
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
    end
  end

  // saturating wait counter; the error is sticky and never aborts the transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_r      <= '0;
      timeout_err_r <= 1'b0;
    end else if (grant_s) begin
      to_cnt_r <= '0;
    end else if (TO_EN && serving_s && !mem_ready && (to_cnt_r != TO_LIMIT)) begin
      to_cnt_r <= to_cnt_r + CNT_W'(1);
      if ((to_cnt_r + CNT_W'(1)) == TO_LIMIT) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  assign mem_read    = mem_read_r;
  assign mem_write   = mem_write_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign timeout_err = timeout_err_r;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_read, i_write, d_read, d_write, mem_ready;
  logic [27:0]  i_addr, d_addr;
  logic [127:0] i_wdata, d_wdata, mem_rdata;

  logic [127:0] a_i_rdata, a_d_rdata, a_mem_wdata, b_i_rdata, b_d_rdata, b_mem_wdata;
  logic         a_i_ready, a_d_ready, a_mem_read, a_mem_write, a_timeout_err;
  logic         b_i_ready, b_d_ready, b_mem_read, b_mem_write, b_timeout_err;
  logic [27:0]  a_mem_addr, b_mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRI(0), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(a_i_rdata), .i_ready(a_i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(a_d_rdata), .d_ready(a_d_ready),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(a_timeout_err)
  );

  mem_arbiter #(.FIXED_PRI(1), .TIMEOUT(0)) dut_fp (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(b_i_rdata), .i_ready(b_i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(b_timeout_err)
  );

  task automatic idle_inputs();
    i_read = 1'b0; i_write = 1'b0; i_addr = 28'd0; i_wdata = 128'd0;
    d_read = 1'b0; d_write = 1'b0; d_addr = 28'd0; d_wdata = 128'd0;
    mem_ready = 1'b0; mem_rdata = 128'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_mem_read, a_mem_write, a_mem_addr, a_mem_wdata, a_timeout_err} !== 158'd0) begin
      errors++;
      $display("FAIL reset_mem: got r=%0b w=%0b a=%0h err=%0b required all zero",
               a_mem_read, a_mem_write, a_mem_addr, a_timeout_err);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({a_i_ready, a_d_ready, b_i_ready, b_d_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b required 0000", {a_i_ready, a_d_ready, b_i_ready, b_d_ready});
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    i_read = 1'b1; i_addr = 28'h0000010;
    #1;
    checks++;
    if (a_mem_read !== 1'b0) begin
      errors++; $display("FAIL read_no_comb_path: got %0b required 0", a_mem_read);
    end
    step();
    checks++;
    if ({a_mem_read, a_mem_write, a_mem_addr} !== {1'b1, 1'b0, 28'h0000010}) begin
      errors++;
      $display("FAIL read_grant: got r=%0b w=%0b a=%0h required r=1 w=0 a=10", a_mem_read, a_mem_write, a_mem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({a_mem_read, a_i_ready, a_d_ready} !== 3'b100) begin
        errors++; $display("FAIL read_wait: got r/ir/dr=%b required 100", {a_mem_read, a_i_ready, a_d_ready});
      end
    end
    mem_ready = 1'b1; mem_rdata = {16{8'hA5}};
    #1;
    checks++;
    if ({a_i_ready, a_d_ready, a_i_rdata} !== {1'b1, 1'b0, {16{8'hA5}}}) begin
      errors++;
      $display("FAIL read_ready: got ir=%0b dr=%0b rdata=%0h required 1 0 a5..a5", a_i_ready, a_d_ready, a_i_rdata);
    end
    step();
    i_read = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if ({a_mem_read, a_mem_write, a_i_ready} !== 3'b000) begin
      errors++; $display("FAIL read_drop: got r/w/ir=%b required 000", {a_mem_read, a_mem_write, a_i_ready});
    end
  endtask

  task automatic test_conflict_rr();
    logic [127:0] w1, w2;
    w1 = {$urandom, $urandom, $urandom, $urandom};
    w2 = {$urandom, $urandom, $urandom, $urandom};
    do_reset();
    i_read = 1'b1; i_addr = 28'h00000A1;
    d_write = 1'b1; d_addr = 28'h00000D2; d_wdata = w1;
    step();
    checks++;
    if ({a_mem_read, a_mem_write, a_mem_addr, a_mem_wdata} !== {1'b0, 1'b1, 28'h00000D2, w1}) begin
      errors++; $display("FAIL rr_first_d: got r=%0b w=%0b a=%0h required D write a=d2", a_mem_read, a_mem_write, a_mem_addr);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({a_d_ready, a_i_ready} !== 2'b10) begin
      errors++; $display("FAIL rr_d_ready: got dr/ir=%b required 10", {a_d_ready, a_i_ready});
    end
    step();
    mem_ready = 1'b0; d_addr = 28'h00000D3; d_wdata = w2;
    checks++;
    if ({a_mem_read, a_mem_write} !== 2'b00) begin
      errors++; $display("FAIL rr_idle_gap: got r/w=%b required 00", {a_mem_read, a_mem_write});
    end
    step();
    checks++;
    if ({a_mem_read, a_mem_write, a_mem_addr} !== {1'b1, 1'b0, 28'h00000A1}) begin
      errors++; $display("FAIL rr_then_i: got r=%0b w=%0b a=%0h required I read a=a1", a_mem_read, a_mem_write, a_mem_addr);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({a_i_ready, a_d_ready} !== 2'b10) begin
      errors++; $display("FAIL rr_i_ready: got ir/dr=%b required 10", {a_i_ready, a_d_ready});
    end
    step();
    mem_ready = 1'b0; i_read = 1'b0;
    step();
    checks++;
    if ({a_mem_write, a_mem_addr, a_mem_wdata} !== {1'b1, 28'h00000D3, w2}) begin
      errors++; $display("FAIL rr_then_d: got w=%0b a=%0h required D write a=d3", a_mem_write, a_mem_addr);
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; d_write = 1'b0;
  endtask

  task automatic test_fixed_pri();
    logic [127:0] rd;
    do_reset();
    i_read = 1'b1; i_addr = 28'h00000B0;
    d_read = 1'b1; d_wdata = {$urandom, $urandom, $urandom, $urandom};
    for (int t = 0; t < 4; t++) begin
      d_addr = 28'h0000100 + 28'(t);
      step();
      checks++;
      if ({b_mem_read, b_mem_write, b_mem_addr, b_mem_wdata} !== {1'b1, 1'b0, 28'h0000100 + 28'(t), d_wdata}) begin
        errors++; $display("FAIL fp_d_wins: txn %0d got r=%0b w=%0b a=%0h required D read", t, b_mem_read, b_mem_write, b_mem_addr);
      end
      rd = {$urandom, $urandom, $urandom, $urandom};
      mem_ready = 1'b1; mem_rdata = rd;
      #1;
      checks++;
      if ({b_d_ready, b_i_ready, b_d_rdata} !== {1'b1, 1'b0, rd}) begin
        errors++; $display("FAIL fp_d_ready: txn %0d got dr=%0b ir=%0b", t, b_d_ready, b_i_ready);
      end
      step();
      mem_ready = 1'b0;
      if (t == 3) d_read = 1'b0;
    end
    step();
    checks++;
    if ({b_mem_read, b_mem_addr} !== {1'b1, 28'h00000B0}) begin
      errors++; $display("FAIL fp_i_after_d: got r=%0b a=%0h required 1 b0", b_mem_read, b_mem_addr);
    end
    rd = {$urandom, $urandom, $urandom, $urandom};
    mem_ready = 1'b1; mem_rdata = rd;
    #1;
    checks++;
    if ({b_i_ready, b_i_rdata} !== {1'b1, rd}) begin
      errors++; $display("FAIL fp_i_ready: got ir=%0b required 1", b_i_ready);
    end
    step();
    mem_ready = 1'b0; i_read = 1'b0;
  endtask

  task automatic test_addr_hold();
    logic [127:0] w1;
    w1 = {$urandom, $urandom, $urandom, $urandom};
    do_reset();
    d_write = 1'b1; d_addr = 28'h0001234; d_wdata = w1;
    step();
    d_addr = 28'h0005678; d_wdata = ~w1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({a_mem_write, a_mem_addr, a_mem_wdata} !== {1'b1, 28'h0001234, w1}) begin
        errors++; $display("FAIL hold_addr: got w=%0b a=%0h required 1 1234", a_mem_write, a_mem_addr);
      end
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; d_write = 1'b0;
    checks++;
    if ({a_mem_write, a_mem_addr} !== {1'b0, 28'h0001234}) begin
      errors++; $display("FAIL hold_complete: got w=%0b a=%0h required 0 1234", a_mem_write, a_mem_addr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    i_read = 1'b1; i_addr = 28'h0000333;
    step();
    for (int k = 1; k <= 19; k++) begin
      step();
      checks++;
      if (a_timeout_err !== ((k >= 8) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL timeout_rise: wait %0d got %0b required %0b", k, a_timeout_err, (k >= 8));
      end
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({a_i_ready, a_mem_read} !== 2'b11) begin
      errors++; $display("FAIL timeout_completes: got ir/r=%b required 11", {a_i_ready, a_mem_read});
    end
    step();
    mem_ready = 1'b0; i_read = 1'b0;
    step();
    checks++;
    if ({a_timeout_err, a_mem_read, b_timeout_err} !== 3'b100) begin
      errors++; $display("FAIL timeout_sticky: got err/r/err_disabled=%b required 100", {a_timeout_err, a_mem_read, b_timeout_err});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    d_write = 1'b1; d_addr = 28'h000CAFE; d_wdata = {4{32'hDEADBEEF}};
    step();
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({a_mem_write, a_d_ready} !== 2'b11) begin
      errors++; $display("FAIL arst_precond: got w/dr=%b required 11", {a_mem_write, a_d_ready});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({a_mem_write, a_mem_read, a_mem_addr, a_d_ready} !== 31'd0) begin
      errors++; $display("FAIL arst_immediate: got w=%0b r=%0b a=%0h dr=%0b required 0", a_mem_write, a_mem_read, a_mem_addr, a_d_ready);
    end
    idle_inputs();
    #1;
    rst = 1'b0;
    step();
    i_read = 1'b1; i_addr = 28'h0000011;
    d_read = 1'b1; d_addr = 28'h0000077;
    step();
    checks++;
    if ({a_mem_read, a_mem_addr} !== {1'b1, 28'h0000077}) begin
      errors++; $display("FAIL arst_d_first: got r=%0b a=%0h required 1 77", a_mem_read, a_mem_addr);
    end
    idle_inputs();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic test_random_traffic();
    bit           has_i, has_d, prev_pi, prev_pd, busy;
    logic         ri, wi, rd, wd;
    logic [1:0]   rw;
    logic [27:0]  ai, ad;
    logic [127:0] wdi, wdd, exp_rd;
    int           win, last, wait_left, served, w;
    has_i = 1'b0; has_d = 1'b0; prev_pi = 1'b0; prev_pd = 1'b0; busy = 1'b0;
    ri = 1'b0; wi = 1'b0; rd = 1'b0; wd = 1'b0;
    ai = 28'd0; ad = 28'd0; wdi = 128'd0; wdd = 128'd0;
    win = 0; last = 0; wait_left = 0; served = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      if (busy && mem_ready) begin
        checks++;
        if ({a_mem_read, a_mem_write} !== 2'b00) begin
          errors++; $display("FAIL rnd_strobe_drop: cycle %0d got r/w=%b required 00", cyc, {a_mem_read, a_mem_write});
        end
        if (win == 1) has_d = 1'b0; else has_i = 1'b0;
        busy = 1'b0; mem_ready = 1'b0; served++;
      end else if (!busy) begin
        checks++;
        if ((a_mem_read | a_mem_write) !== (prev_pi | prev_pd)) begin
          errors++; $display("FAIL rnd_grant: cycle %0d got strobe=%0b required %0b", cyc, (a_mem_read | a_mem_write), (prev_pi | prev_pd));
        end
        if (prev_pi | prev_pd) begin
          // alternate on conflict; a lone requester always wins
          w = (prev_pi && prev_pd) ? ((last == 1) ? 0 : 1) : (prev_pd ? 1 : 0);
          checks++;
          if ({a_mem_write, a_mem_read, a_mem_addr, a_mem_wdata} !==
              ((w == 1) ? {wd, rd & ~wd, ad, wdd} : {wi, ri & ~wi, ai, wdi})) begin
            errors++; $display("FAIL rnd_bundle: cycle %0d winner %0d got w=%0b r=%0b a=%0h", cyc, w, a_mem_write, a_mem_read, a_mem_addr);
          end
          last = w; win = w; busy = 1'b1; wait_left = $urandom_range(0, 4);
        end
      end else begin
        checks++;
        if ((a_mem_read | a_mem_write) !== 1'b1) begin
          errors++; $display("FAIL rnd_hold: cycle %0d strobe dropped early", cyc);
        end
        if (wait_left > 0) wait_left--;
      end
      if (!has_i && $urandom_range(0, 2) == 0) begin
        has_i = 1'b1; rw = 2'($urandom_range(1, 3)); ri = rw[0]; wi = rw[1];
        ai = 28'($urandom); wdi = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!has_d && $urandom_range(0, 2) == 0) begin
        has_d = 1'b1; rw = 2'($urandom_range(1, 3)); rd = rw[0]; wd = rw[1];
        ad = 28'($urandom); wdd = {$urandom, $urandom, $urandom, $urandom};
      end
      i_read = has_i & ri; i_write = has_i & wi; i_addr = ai; i_wdata = wdi;
      d_read = has_d & rd; d_write = has_d & wd; d_addr = ad; d_wdata = wdd;
      prev_pi = has_i; prev_pd = has_d;
      if (busy && wait_left == 0) begin
        exp_rd = {$urandom, $urandom, $urandom, $urandom};
        mem_ready = 1'b1; mem_rdata = exp_rd;
        #1;
        checks++;
        if (((win == 1) ? {a_d_ready, a_i_ready, a_d_rdata} : {a_i_ready, a_d_ready, a_i_rdata}) !== {1'b1, 1'b0, exp_rd}) begin
          errors++; $display("FAIL rnd_ready: cycle %0d winner %0d got ir=%0b dr=%0b", cyc, win, a_i_ready, a_d_ready);
        end
      end
    end
    checks++;
    if (served < 100) begin
      errors++; $display("FAIL rnd_progress: served %0d required at least 100", served);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_conflict_rr();
    test_fixed_pri();
    test_addr_hold();
    test_timeout();
    test_async_reset();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one 128-bit slow-memory port between the I-cache and D-cache miss/write-back interfaces.
- Both caches present the same read/write/addr/wdata/ready bundle they would drive to a private slow memory. The arbiter grants one requester at a time and holds the grant until the memory signals ready.
- Sits between the two cache instances and a single unified slow memory, replacing the separate _I/_D memory ports.

Parameters:
- FIXED_PRI, 0, 1 = D-cache always wins a conflict; 0 = round-robin on conflict.
- TIMEOUT, 1023, cycles a granted transaction may wait for mem_ready before the sticky error is set; 0 disables the check.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
i_read  in  1  I-cache read request (level, held until i_ready)
i_write  in  1  I-cache write request
i_addr  in  28  I-cache line address [31:4]
i_wdata  in  128  I-cache write line
i_rdata  out  128  read line returned to I-cache
i_ready  out  1  transaction-complete pulse to I-cache
d_read  in  1  D-cache read request
d_write  in  1  D-cache write request
d_addr  in  28  D-cache line address [31:4]
d_wdata  in  128  D-cache write line
d_rdata  out  128  read line returned to D-cache
d_ready  out  1  transaction-complete pulse to D-cache
mem_read  out  1  unified memory read strobe (registered)
mem_write  out  1  unified memory write strobe (registered)
mem_addr  out  28  unified memory line address (registered)
mem_wdata  out  128  unified memory write line (registered)
mem_rdata  in  128  unified memory read line
mem_ready  in  1  unified memory completion
timeout_err  out  1  sticky: a transaction exceeded TIMEOUT cycles

Behaviour:
- Reset values: all mem_* outputs 0, state IDLE, last_grant = I (so D wins the first conflict), timeout counter 0, timeout_err 0. i_ready and d_ready are 0 because state is IDLE.
- Requester X is pending when X_read | X_write.
- States and transitions:
  - IDLE: neither pending → stay IDLE. Exactly one pending → go to SERVE_X. Both pending → D if FIXED_PRI=1; otherwise the requester not equal to last_grant.
  - On the IDLE→SERVE_X edge: register mem_addr, mem_wdata, mem_read, mem_write from X, and set last_grant = X.
  - If X_read and X_write are both 1, write wins: mem_write=1, mem_read=0.
  - SERVE_X: mem_* held constant. X_ready = mem_ready (combinational); X_rdata = mem_rdata (combinational). The other requester's ready stays 0.
  - On the edge sampling mem_ready=1: mem_read and mem_write clear to 0, go to IDLE.
- Latency: request seen in IDLE at edge t → mem strobe asserted after t. X_ready is asserted in the same cycle as mem_ready. Strobes drop one cycle later. Minimum bus turnaround is one IDLE cycle between transactions, so a stale request is never re-granted (caches drop requests on the ready edge).
- A non-granted requester's inputs are ignored. Its request must stay pending; it is served next.
- Round-robin guarantees a continuously requesting cache waits at most one other transaction.
- Changes to the granted requester's inputs during SERVE are ignored, because mem_* are latched.
- i_rdata / d_rdata drive mem_rdata unconditionally; they are only valid while the matching ready is 1.
- Timeout counter:
  - Clears on entry to SERVE and increments each SERVE cycle without mem_ready.
  - Saturates at TIMEOUT. When it reaches TIMEOUT, timeout_err = 1 (sticky until rst).
  - The transaction is not aborted; the arbiter keeps waiting.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronous); the in-flight memory operation is abandoned.

Decomposition:
- Shared package: state encoding (IDLE, SERVE_I, SERVE_D), the requester-id constants (REQ_I, REQ_D), and the line-address and line-data width constants (28, 128).
- One natural sub-module, mem_arb_rr_pick: a combinational two-way picker (inputs: pend_i, pend_d, last_grant, FIXED_PRI; output: grant id plus valid).
- Everything else lives in mem_arbiter.

Test Plan:
1. i_read, addr 0x0000010, alone; mem_ready after 5 cycles with rdata 0xA5…A5 → mem_read rises 1 cycle after request; i_ready=1 and i_rdata=0xA5…A5 in the ready cycle; mem_read=0 the next cycle; d_ready never 1.
2. i_read and d_write asserted in the same cycle, FIXED_PRI=0, from reset → D served first (mem_write=1, mem_addr=d_addr); then one IDLE cycle; then I served. Repeat the conflict → I served first, then D.
3. FIXED_PRI=1, both requesting continuously for 4 transactions → D granted every time while D is pending; I is granted only in an IDLE cycle when D is not pending.
4. Granted D changes d_addr from 0x1234 to 0x5678 mid-SERVE → mem_addr stays 0x1234 until mem_ready.
5. TIMEOUT=8, mem_ready withheld for 20 cycles → timeout_err rises on SERVE cycle 8 and stays 1 after completion; the transaction still completes normally.
6. rst asserted during SERVE_D with mem_write=1 → mem_write, mem_read, mem_addr and d_ready go to 0 without waiting for a clock edge; after release, the first conflict grants D.
